// File: rtl/vga_plot_sink.sv
// vga_plot_fifo: generic pointer-based FIFO with an occupancy count (DEPTH must be a power of two).
// Latency: a push is visible at the head and in o_level the cycle after the write edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_push_dat write side;
//        i_pop/o_pop_dat read side (head is shown combinationally); o_level occupancy 0..DEPTH.
module vga_plot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_dat,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_level   = r_level;
endmodule

// vga_plot_sink: range-checks plotted pixels, packs colour, queues them and writes them to a framebuffer port.
// Latency: plot sampled at edge N -> mem_wren with its address/data in the cycle after edge N+1.
// Backpressure: mem_ready low holds the write; the FIFO fills, busy flags full, further plots are dropped and counted.
// Ports: CLOCK_50/resetn clock and async active-low reset; VGA_X/VGA_Y/VGA_COLOR/plot pixel input;
//        busy FIFO full; mem_addr/mem_data/mem_wren/mem_ready framebuffer write handshake;
//        drop_count saturating count of discarded plots; fifo_level current FIFO occupancy.
module vga_plot_sink #(
    parameter logic [55:0] RESOLUTION  = "640x480",
    parameter int          COLOR_DEPTH = 9,
    parameter int          FIFO_DEPTH  = 4,
    localparam int         W  = (RESOLUTION == "320x240") ? 320 :
                                (RESOLUTION == "160x120") ? 160 : 640,
    localparam int         H  = (W == 320) ? 240 : (W == 160) ? 120 : 480,
    localparam int         A  = (W == 320) ? 17 : (W == 160) ? 15 : 19,
    localparam int         LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic [9:0]             VGA_X,
    input  logic [8:0]             VGA_Y,
    input  logic [23:0]            VGA_COLOR,
    input  logic                   plot,
    output logic                   busy,
    output logic [A-1:0]           mem_addr,
    output logic [COLOR_DEPTH-1:0] mem_data,
    output logic                   mem_wren,
    input  logic                   mem_ready,
    output logic [7:0]             drop_count,
    output logic [LW-1:0]          fifo_level
);
    localparam int K  = COLOR_DEPTH / 3;
    localparam int EW = 10 + 9 + COLOR_DEPTH;

    localparam logic [9:0]    W_X      = 10'(W);
    localparam logic [8:0]    H_Y      = 9'(H);
    localparam logic [A-1:0]  W_A      = A'(W);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    logic                   w_on_screen;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;
    logic                   w_empty;
    logic [COLOR_DEPTH-1:0] w_pack;
    logic [EW-1:0]          w_head;
    logic [9:0]             w_head_x;
    logic [8:0]             w_head_y;
    logic [COLOR_DEPTH-1:0] w_head_c;
    logic [A-1:0]           w_addr;

    logic [0:0]             r_state;
    logic [A-1:0]           r_addr;
    logic [COLOR_DEPTH-1:0] r_data;
    logic [7:0]             r_drop;

    // Upper bits of VGA_X/VGA_Y beyond the resolution make the pixel fail the compare.
    assign w_on_screen = (VGA_X < W_X) && (VGA_Y < H_Y);

    // busy comes from the start-of-cycle level, so a pop this cycle cannot rescue a push into a full FIFO.
    assign busy    = (fifo_level == FULL_LVL);
    assign w_empty = (fifo_level == '0);

    assign w_push = plot && w_on_screen && !busy;
    // Off-screen and busy together still count as a single drop.
    assign w_drop = plot && !w_push;

    assign w_pack = {VGA_COLOR[23 -: K], VGA_COLOR[15 -: K], VGA_COLOR[7 -: K]};

    vga_plot_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (CLOCK_50),
        .i_rst_n    (resetn),
        .i_push     (w_push),
        .i_push_dat ({VGA_X, VGA_Y, w_pack}),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_level    (fifo_level)
    );

    assign w_head_x = w_head[EW-1 -: 10];
    assign w_head_y = w_head[COLOR_DEPTH +: 9];
    assign w_head_c = w_head[COLOR_DEPTH-1:0];

    // Full-width product: y*W never exceeds W*H-1, which fits in A bits.
    assign w_addr = (A'(w_head_y) * W_A) + A'(w_head_x);

    // Load the output register when idle, or when the current write is accepted.
    assign w_pop = !w_empty && ((r_state == S_IDLE) || mem_ready);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            if (w_pop) begin
                r_addr  <= w_addr;
                r_data  <= w_head_c;
                r_state <= S_WRITE;
            end else if ((r_state == S_WRITE) && mem_ready) begin
                r_state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign mem_wren   = (r_state == S_WRITE);
    assign mem_addr   = r_addr;
    assign mem_data   = r_data;
    assign drop_count = r_drop;
endmodule

// File: tb/tb_vga_plot_sink.sv
// tb_vga_plot_sink: table-driven and sequence checks of vga_plot_sink at 640x480 / 9-bit / depth 4.
// Latency: expected writes are queued at stimulus time and matched when the DUT completes a write.
// Backpressure: mem_ready is driven by the bench to stall, release and reset mid-write.
module tb_vga_plot_sink;
    logic        CLOCK_50  = 1'b0;
    logic        resetn    = 1'b0;
    logic [9:0]  VGA_X     = '0;
    logic [8:0]  VGA_Y     = '0;
    logic [23:0] VGA_COLOR = '0;
    logic        plot      = 1'b0;
    logic        mem_ready = 1'b0;
    logic        busy;
    logic [18:0] mem_addr;
    logic [8:0]  mem_data;
    logic        mem_wren;
    logic [7:0]  drop_count;
    logic [2:0]  fifo_level;

    int total    = 0;
    int bad      = 0;
    int n_wr     = 0;
    int exp_drop = 0;

    typedef struct {
        int addr;
        int data;
    } ex_t;
    ex_t exp_q[$];

    typedef struct {
        int          x;
        int          y;
        logic [23:0] c;
        bit          wr;
        int          addr;
        int          data;
    } vec_t;
    vec_t vt[10];

    vga_plot_sink dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .VGA_X      (VGA_X),
        .VGA_Y      (VGA_Y),
        .VGA_COLOR  (VGA_COLOR),
        .plot       (plot),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_ready  (mem_ready),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic int pack9(input logic [23:0] c);
        return int'({c[23:21], c[15:13], c[7:5]});
    endfunction

    task automatic plot_px(input int x, input int y, input logic [23:0] c,
                           input bit wr, input int addr, input int data);
        step();
        VGA_X     = 10'(x);
        VGA_Y     = 9'(y);
        VGA_COLOR = c;
        plot      = 1'b1;
        if (wr) begin
            exp_q.push_back('{addr: addr, data: data});
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 12 && exp_q.size() != 0; k++) begin
            @(negedge CLOCK_50);
        end
        chk(nm, exp_q.size(), 0);
    endtask

    // Scoreboard: every accepted write must match the oldest expected entry.
    always @(negedge CLOCK_50) begin
        if (mem_wren && mem_ready) begin
            ex_t e;
            n_wr++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %0d, want no write", mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), e.addr);
                chk("wr_data", 32'(mem_data), e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        // x, y, colour, write expected, address, packed colour
        vt[0] = '{3,    2,   24'hFF8000, 1'b1, 1283,   9'b111_100_000};
        vt[1] = '{639,  479, 24'h000000, 1'b1, 307199, 0};
        vt[2] = '{640,  0,   24'hFFFFFF, 1'b0, 0,      0};
        vt[3] = '{0,    480, 24'hFFFFFF, 1'b0, 0,      0};
        vt[4] = '{0,    0,   24'hFFFFFF, 1'b1, 0,      9'h1FF};
        vt[5] = '{1023, 511, 24'h123456, 1'b0, 0,      0};
        vt[6] = '{100,  200, 24'h204080, 1'b1, 128100, 9'b001_010_100};
        vt[7] = '{639,  0,   24'hE0E0E0, 1'b1, 639,    9'h1FF};
        vt[8] = '{0,    479, 24'h1F1F1F, 1'b1, 306560, 0};
        vt[9] = '{5,    5,   24'hA5C3E7, 1'b1, 3205,   9'b101_110_111};

        // Reset values
        repeat (2) @(negedge CLOCK_50);
        chk("rst_busy",  32'(busy),       0);
        chk("rst_wren",  32'(mem_wren),   0);
        chk("rst_addr",  32'(mem_addr),   0);
        chk("rst_data",  32'(mem_data),   0);
        chk("rst_drop",  32'(drop_count), 0);
        chk("rst_level", 32'(fifo_level), 0);
        step();
        resetn    = 1'b1;
        mem_ready = 1'b1;

        // Basic write with exact latency: one pulse, two cycles after the sampling edge
        plot_px(3, 2, 24'hFF8000, 1'b1, 1283, 9'b111_100_000);
        step();
        plot = 1'b0;
        @(negedge CLOCK_50);
        chk("lat_wren_n0",  32'(mem_wren),   0);
        chk("lat_level_n0", 32'(fifo_level), 1);
        step();
        @(negedge CLOCK_50);
        chk("lat_wren_n1", 32'(mem_wren), 1);
        chk("lat_addr_n1", 32'(mem_addr), 1283);
        step();
        @(negedge CLOCK_50);
        chk("lat_wren_n2", 32'(mem_wren), 0);
        chk("lat_drain",   exp_q.size(),  0);

        // Table: one plot at a time, check write and drop count
        for (int i = 0; i < 10; i++) begin
            plot_px(vt[i].x, vt[i].y, vt[i].c, vt[i].wr, vt[i].addr, vt[i].data);
            step();
            plot = 1'b0;
            @(negedge CLOCK_50);
            drain($sformatf("vec%0d_drain", i));
            chk($sformatf("vec%0d_drop", i), 32'(drop_count), exp_drop);
        end

        // Backpressure: 6 plots with mem_ready low; 5 held, 6th dropped
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [23:0] c;
            c = 24'h203040 * 24'(i + 1);
            plot_px(10 + i, 1, c, i < 5, 640 + 10 + i, pack9(c));
            if (i == 4) begin
                @(negedge CLOCK_50);
                chk("bp_busy_pre",  32'(busy),       0);
                chk("bp_level_pre", 32'(fifo_level), 3);
            end
            if (i == 5) begin
                @(negedge CLOCK_50);
                chk("bp_busy_full",  32'(busy),       1);
                chk("bp_level_full", 32'(fifo_level), 4);
                chk("bp_wren",       32'(mem_wren),   1);
                chk("bp_addr_head",  32'(mem_addr),   650);
            end
        end
        step();
        plot = 1'b0;
        @(negedge CLOCK_50);
        chk("bp_drop", 32'(drop_count), exp_drop);
        chk("bp_busy", 32'(busy),       1);
        repeat (2) @(negedge CLOCK_50);
        chk("bp_hold_addr", 32'(mem_addr), 650);
        chk("bp_hold_wren", 32'(mem_wren), 1);
        step();
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            chk($sformatf("bp_b2b%0d", i), 32'(mem_wren), 1);
        end
        @(negedge CLOCK_50);
        chk("bp_end_wren", 32'(mem_wren), 0);
        chk("bp_drain",    exp_q.size(),  0);

        // Full FIFO with simultaneous accept and plot: head written, new pixel dropped
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            plot_px(20 + i, 3, 24'h40C020 + 24'(i), 1'b1, 3 * 640 + 20 + i, pack9(24'h40C020 + 24'(i)));
        end
        step();
        plot = 1'b0;
        @(negedge CLOCK_50);
        chk("pp_level_full", 32'(fifo_level), 4);
        chk("pp_busy_full",  32'(busy),       1);
        plot_px(30, 3, 24'hFFFFFF, 1'b0, 0, 0);
        mem_ready = 1'b1;
        step();
        plot = 1'b0;
        @(negedge CLOCK_50);
        chk("pp_level", 32'(fifo_level), 3);
        chk("pp_drop",  32'(drop_count), exp_drop);
        chk("pp_busy",  32'(busy),       0);
        drain("pp_drain");

        // Reset while a write is stalled with 3 entries queued
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            plot_px(40 + i, 7, 24'hFFFFFF, 1'b1, 7 * 640 + 40 + i, 9'h1FF);
        end
        step();
        plot = 1'b0;
        @(negedge CLOCK_50);
        chk("mr_level", 32'(fifo_level), 3);
        chk("mr_wren",  32'(mem_wren),   1);
        resetn = 1'b0;
        #1;
        chk("mr_busy",     32'(busy),       0);
        chk("mr_wren_rst", 32'(mem_wren),   0);
        chk("mr_addr",     32'(mem_addr),   0);
        chk("mr_data",     32'(mem_data),   0);
        chk("mr_drop",     32'(drop_count), 0);
        chk("mr_level0",   32'(fifo_level), 0);
        exp_q.delete();
        exp_drop = 0;
        step();
        resetn    = 1'b1;
        mem_ready = 1'b1;
        saved     = n_wr;
        repeat (8) @(negedge CLOCK_50);
        chk("mr_no_stale",  n_wr,           saved);
        chk("mr_wren_idle", 32'(mem_wren),  0);

        // Drop counter saturation
        for (int i = 0; i < 254; i++) begin
            plot_px(700, 10, 24'h0, 1'b0, 0, 0);
        end
        step();
        plot = 1'b0;
        @(negedge CLOCK_50);
        chk("sat_254", 32'(drop_count), 254);
        for (int i = 0; i < 46; i++) begin
            plot_px(5, 490, 24'h0, 1'b0, 0, 0);
        end
        step();
        plot = 1'b0;
        @(negedge CLOCK_50);
        chk("sat_255", 32'(drop_count), 255);
        chk("sat_no_write", n_wr, saved);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
